// File: rtl/accelbrot_com_pkg.sv
// rtl/accelbrot_com_pkg.sv - shared sizing constants for the accelbrot word-serial datapath
package accelbrot_com_pkg;

   // Defaults shared with the multi-word multipliers that feed the gather
   localparam int NWORDS_DEF = 8;
   localparam int WWIDTH_DEF = 34;
   localparam int IWIDTH_DEF = 6;

endpackage

// File: rtl/accelbrot_com_fifo2.sv
// rtl/accelbrot_com_fifo2.sv - 2-entry registered FIFO, output taken directly from the head register
module accelbrot_com_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       count_q, count_d;
   logic             do_pop;
   logic             do_push;

   assign valid_o = (count_q != 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign data_o  = head_q;

   // A push into a full FIFO is accepted only when the head leaves on the same edge
   assign do_pop  = pop_i && valid_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Next-state for head/tail/occupancy; head keeps its last value when the FIFO drains
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (do_push) begin
               head_d  = push_data_i;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (do_push && do_pop) begin
               head_d = push_data_i;
            end else if (do_push) begin
               tail_d  = push_data_i;
               count_d = 2'd2;
            end else if (do_pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            if (do_pop) begin
               head_d  = tail_q;
               count_d = 2'd1;
               if (do_push) begin
                  tail_d  = push_data_i;
                  count_d = 2'd2;
               end
            end
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/accelbrot_com_word_gather.sv
// rtl/accelbrot_com_word_gather.sv - collects NWORDS LSW-first words into a block; ACCELBROT_GATHER_CHECK_EN enables framing checks
module accelbrot_com_word_gather
   import accelbrot_com_pkg::*;
#(
   parameter  int NWORDS = NWORDS_DEF,
   parameter  int WWIDTH = WWIDTH_DEF,
   localparam int BWIDTH = NWORDS * WWIDTH
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [WWIDTH-1:0] s_word,
   input  logic              s_start,
   input  logic              s_valid,
   output logic [BWIDTH-1:0] m_block,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic              err_clr,
   output logic              err_ovf,
   output logic              err_frame
);

   localparam int            CW   = $clog2(NWORDS);
   localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BWIDTH-1:0] asm_q, asm_d;
   logic              push;
   logic              pop;
   logic              full;
   logic              drop;
   logic              err_ovf_q, err_ovf_d;

   // Collector: place each word in its slot; the completed block (final word included) is pushed
   always_comb begin
      cnt_d = cnt_q;
      asm_d = asm_q;
      push  = 1'b0;
      if (s_valid) begin
         if (s_start) begin
            asm_d[WWIDTH-1:0] = s_word;
            cnt_d             = CW'(1);
         end else if (cnt_q != '0) begin
            for (int i = 1; i < NWORDS; i++) begin
               if (cnt_q == CW'(i)) begin
                  asm_d[i*WWIDTH +: WWIDTH] = s_word;
               end
            end
            if (cnt_q == LAST) begin
               cnt_d = '0;
               push  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   // Collector state registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
         asm_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         asm_q <= asm_d;
      end
   end

   assign pop  = m_valid && m_ready;
   assign drop = push && full && !pop;

   accelbrot_com_fifo2 #(
      .WIDTH(BWIDTH)
   ) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (push),
      .push_data_i(asm_d),
      .full_o     (full),
      .pop_i      (pop),
      .valid_o    (m_valid),
      .data_o     (m_block)
   );

   // Sticky overflow flag: a drop in the same cycle as err_clr leaves it set
   always_comb begin
      err_ovf_d = err_clr ? 1'b0 : err_ovf_q;
      if (drop) begin
         err_ovf_d = 1'b1;
      end
   end

   // Overflow flag register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_ovf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
      end
   end

   assign err_ovf = err_ovf_q;

`ifdef ACCELBROT_GATHER_CHECK_EN
   logic err_frame_q, err_frame_d;
   logic frame_evt;

   // Short frame (restart mid-block) or orphan word (continuation with no open frame)
   assign frame_evt = s_valid && ((s_start && (cnt_q != '0)) || (!s_start && (cnt_q == '0)));

   // Sticky framing flag, set wins over clear
   always_comb begin
      err_frame_d = err_clr ? 1'b0 : err_frame_q;
      if (frame_evt) begin
         err_frame_d = 1'b1;
      end
   end

   // Framing flag register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         err_frame_q <= 1'b0;
      end else begin
         err_frame_q <= err_frame_d;
      end
   end

   assign err_frame = err_frame_q;
`else
   assign err_frame = 1'b0;
`endif

endmodule
